async_receiver: RTL and testbench

UART receive path: recovers 8N1 bytes from the asynchronous serial input `RxD` and presents each byte with a one-cycle strobe. It is the receive counterpart of the UART transmitter and shares its `ClkFrequency`/`Baud` parameters, so a matched pair forms a full-duplex link on the FPGA's serial pins. It oversamples the line, resynchronises it, rejects glitches, samples each bit at mid-period and, when configured, flags framing errors.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_os_tick_gen.sv | 30 +++
 rtl/async_receiver.sv | 157 +++++++++++++++
 tb/tb_async_receiver.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the
// oversample-tick accumulator sizing used by both the receiver and transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [3:0] {
        RX_IDLE,
        RX_START,
        RX_BIT0, RX_BIT1, RX_BIT2, RX_BIT3,
        RX_BIT4, RX_BIT5, RX_BIT6, RX_BIT7,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Eight fractional bits beyond the clock/tick ratio keep the average rate error small.
    function automatic int tick_acc_width(input longint clk_hz, input longint tick_hz);
        int w;
        w = 0;
        while ((longint'(1) << w) < clk_hz / tick_hz) w++;
        return w + 8;
    endfunction

    function automatic longint tick_acc_inc(input longint clk_hz, input longint tick_hz,
                                            input int width);
        return ((tick_hz << width) + clk_hz / 2) / clk_hz;
    endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Free-running fractional accumulator producing one-clock ticks at Baud*Oversampling
// on average; the tick is the accumulator carry.
module uart_os_tick_gen
    import uart_pkg::*;
#(
    parameter int ClkFrequency = 12000000,
    parameter int Baud         = 9600,
    parameter int Oversampling = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam longint TICK_HZ = longint'(Baud) * longint'(Oversampling);
    localparam int     ACC_W   = tick_acc_width(longint'(ClkFrequency), TICK_HZ);
    localparam logic [ACC_W:0] ACC_INC =
        (ACC_W + 1)'(tick_acc_inc(longint'(ClkFrequency), TICK_HZ, ACC_W));

    logic [ACC_W:0] acc;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else        acc <= {1'b0, acc[ACC_W-1:0]} + ACC_INC;
    end

    assign tick = acc[ACC_W];

endmodule

// File: rtl/async_receiver.sv
// 8N1 UART receiver: synchroniser, glitch filter, mid-bit sampling FSM.
// Define UART_RX_FRAMING_CHECK_EN to drop frames with a bad stop bit and pulse RxD_frame_err.
module async_receiver
    import uart_pkg::*;
#(
    parameter int ClkFrequency = 12000000,
    parameter int Baud         = 9600,
    parameter int Oversampling = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_busy,
    output logic       RxD_frame_err
);

    localparam int OS_W = $clog2(Oversampling);
    localparam logic [OS_W-1:0] HALF_LAST = OS_W'(Oversampling / 2 - 1);
    localparam logic [OS_W-1:0] FULL_LAST = OS_W'(Oversampling - 1);

    generate
        if (Oversampling < 8 || (Oversampling & (Oversampling - 1)) != 0) begin : g_bad_os
            $error("async_receiver: Oversampling must be a power of two and at least 8");
        end
    endgenerate

    logic os_tick;

    uart_os_tick_gen #(
        .ClkFrequency(ClkFrequency),
        .Baud        (Baud),
        .Oversampling(Oversampling)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (os_tick)
    );

    logic       rx_meta, rx_sync;
    logic [1:0] filt_cnt, filt_cnt_next;
    logic       filt_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rx_sync <= rx_meta;
        end
    end

    always_comb begin
        filt_cnt_next = filt_cnt;
        if (rx_sync && filt_cnt != 2'd3)       filt_cnt_next = filt_cnt + 2'd1;
        else if (!rx_sync && filt_cnt != 2'd0) filt_cnt_next = filt_cnt - 2'd1;
    end

    // The filtered bit only flips at the saturation points, giving hysteresis.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= 2'd3;
            filt_bit <= 1'b1;
        end else if (os_tick) begin
            filt_cnt <= filt_cnt_next;
            if (filt_cnt_next == 2'd3)      filt_bit <= 1'b1;
            else if (filt_cnt_next == 2'd0) filt_bit <= 1'b0;
        end
    end

    rx_state_t                  state_q, state_d;
    logic [OS_W-1:0]            os_cnt;
    logic [UART_DATA_BITS-1:0]  shift_q;
    logic                       shift_en;
    logic                       deliver;
`ifdef UART_RX_FRAMING_CHECK_EN
    logic                       bad_frame;
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        deliver  = 1'b0;
`ifdef UART_RX_FRAMING_CHECK_EN
        bad_frame = 1'b0;
`endif
        if (os_tick) begin
            unique case (state_q)
                RX_IDLE: if (!filt_bit) state_d = RX_START;
                RX_START: if (os_cnt == HALF_LAST) state_d = filt_bit ? RX_IDLE : RX_BIT0;
                RX_BIT0, RX_BIT1, RX_BIT2, RX_BIT3,
                RX_BIT4, RX_BIT5, RX_BIT6, RX_BIT7: begin
                    if (os_cnt == FULL_LAST) begin
                        shift_en = 1'b1;
                        state_d  = rx_state_t'(state_q + 4'd1);
                    end
                end
                RX_STOP: begin
                    if (os_cnt == FULL_LAST) begin
                        if (filt_bit) begin
                            deliver = 1'b1;
                            state_d = RX_IDLE;
                        end else begin
`ifdef UART_RX_FRAMING_CHECK_EN
                            bad_frame = 1'b1;
`else
                            deliver = 1'b1;
`endif
                            // A held-low line must return high before another start is accepted.
                            state_d = RX_WAIT_HIGH;
                        end
                    end
                end
                RX_WAIT_HIGH: if (filt_bit) state_d = RX_IDLE;
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            os_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) os_cnt <= '0;
            else if (os_tick)       os_cnt <= os_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q        <= '0;
            RxD_data       <= '0;
            RxD_data_ready <= 1'b0;
        end else begin
            RxD_data_ready <= deliver;
            if (shift_en) shift_q  <= {filt_bit, shift_q[UART_DATA_BITS-1:1]};
            if (deliver)  RxD_data <= shift_q;
        end
    end

`ifdef UART_RX_FRAMING_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) RxD_frame_err <= 1'b0;
        else        RxD_frame_err <= bad_frame;
    end
`else
    assign RxD_frame_err = 1'b0;
`endif

    assign RxD_busy = (state_q != RX_IDLE) && (state_q != RX_WAIT_HIGH);

endmodule

// File: tb/tb_async_receiver.sv
// Self-checking bench for async_receiver: vector table, hand-written corner sequences
// and random frames scored against a byte-level model of the 8N1 line protocol.
module tb_async_receiver;

    localparam int CLK_HZ   = 1600000;
    localparam int BAUD     = 100000;
    localparam int OS       = 8;
    localparam int BIT_CLKS = CLK_HZ / BAUD;
`ifdef UART_RX_FRAMING_CHECK_EN
    localparam bit FRAMING = 1'b1;
`else
    localparam bit FRAMING = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rxd_data;
    logic       rxd_data_ready, rxd_busy, rxd_frame_err;

    async_receiver #(
        .ClkFrequency(CLK_HZ),
        .Baud        (BAUD),
        .Oversampling(OS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .RxD           (rxd),
        .RxD_data      (rxd_data),
        .RxD_data_ready(rxd_data_ready),
        .RxD_busy      (rxd_busy),
        .RxD_frame_err (rxd_frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: logs every delivered byte with its cycle, counts error pulses and busy cycles,
    // and flags overlapping or stretched strobes.
    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    int         err_cnt = 0;
    int         busy_cnt = 0;
    int         viol_cnt = 0;
    logic       prev_ready = 1'b0;
    logic       prev_err = 1'b0;

    always @(negedge clk) begin
        if (rxd_data_ready) begin
            rx_q.push_back(rxd_data);
            rx_cyc.push_back(cyc);
        end
        if (rxd_frame_err) err_cnt <= err_cnt + 1;
        if (rxd_busy) busy_cnt <= busy_cnt + 1;
        if ((rxd_data_ready && rxd_frame_err) || (rxd_data_ready && prev_ready) ||
            (rxd_frame_err && prev_err))
            viol_cnt <= viol_cnt + 1;
        prev_ready <= rxd_data_ready;
        prev_err   <= rxd_frame_err;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"},  int'(rxd_data), 0);
        check({tag, "_ready"}, int'(rxd_data_ready), 0);
        check({tag, "_busy"},  int'(rxd_busy), 0);
        check({tag, "_err"},   int'(rxd_frame_err), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_ready;
        int         exp_err;
    } vec_t;

    localparam int NUM_VECS = 6;
    vec_t vecs[NUM_VECS];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] last_data;
        logic [7:0] exp_q[$];
        int rb, eb, bc, exp_err;

        vecs[0] = '{8'h55, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 0};
        vecs[3] = '{8'h80, 1'b1, 1, 0};
        vecs[4] = '{8'h01, 1'b1, 1, 0};
        vecs[5] = '{8'hC6, 1'b0, FRAMING ? 0 : 1, FRAMING ? 1 : 0};

        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        idle_bits(2);
        last_data = 8'h00;

        for (int i = 0; i < NUM_VECS; i++) begin
            rb = rx_q.size();
            eb = err_cnt;
            send_frame(vecs[i].data, vecs[i].stop);
            idle_bits(3);
            if (vecs[i].exp_ready != 0) last_data = vecs[i].data;
            check($sformatf("vec%0d_ready", i), rx_q.size() - rb, vecs[i].exp_ready);
            check($sformatf("vec%0d_err", i), err_cnt - eb, vecs[i].exp_err);
            check($sformatf("vec%0d_data", i), int'(rxd_data), int'(last_data));
            check($sformatf("vec%0d_busy", i), int'(rxd_busy), 0);
        end

        // Back-to-back frames: one frame period (10 bits) between strobes.
        rb = rx_q.size();
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        idle_bits(3);
        check("b2b_count", rx_q.size() - rb, 2);
        if (rx_q.size() >= rb + 2) begin
            check("b2b_first", int'(rx_q[rb]), 8'hA3);
            check("b2b_second", int'(rx_q[rb+1]), 8'h0F);
            check("b2b_spacing", rx_cyc[rb+1] - rx_cyc[rb], 10 * BIT_CLKS);
        end
        last_data = 8'h0F;

        // Glitches: 1 clock never touches the FSM, 4 clocks never reach the start
        // threshold, 8 clocks enter START and are rejected at the mid-bit check.
        rb = rx_q.size(); eb = err_cnt; bc = busy_cnt;
        rxd = 1'b0; @(negedge clk);
        idle_bits(3);
        check("glitch1_busy", busy_cnt - bc, 0);
        check("glitch1_ready", rx_q.size() - rb, 0);

        rb = rx_q.size();
        rxd = 1'b0; repeat (4) @(negedge clk);
        idle_bits(3);
        check("glitch4_ready", rx_q.size() - rb, 0);
        check("glitch4_busy_end", int'(rxd_busy), 0);

        rb = rx_q.size(); bc = busy_cnt;
        rxd = 1'b0; repeat (8) @(negedge clk);
        idle_bits(3);
        check("glitch8_started", int'(busy_cnt - bc > 0), 1);
        check("glitch8_ready", rx_q.size() - rb, 0);
        check("glitch8_busy_end", int'(rxd_busy), 0);
        check("glitch8_err", err_cnt - eb, 0);
        check("glitch8_data", int'(rxd_data), int'(last_data));

        // Bad stop bit followed by a 50-bit break, then a clean frame.
        rb = rx_q.size(); eb = err_cnt;
        send_frame(8'h3C, 1'b0);
        for (int i = 0; i < 50; i++) drive_bit(1'b0);
        idle_bits(3);
        check("break_ready", rx_q.size() - rb, FRAMING ? 0 : 1);
        check("break_err", err_cnt - eb, FRAMING ? 1 : 0);
        if (!FRAMING) last_data = 8'h3C;
        check("break_data", int'(rxd_data), int'(last_data));
        rb = rx_q.size(); eb = err_cnt;
        send_frame(8'h81, 1'b1);
        idle_bits(3);
        check("after_break_ready", rx_q.size() - rb, 1);
        check("after_break_data", int'(rxd_data), 8'h81);
        check("after_break_err", err_cnt - eb, 0);

        // Reset in the middle of BIT4 of 0xFF, then a clean 0x12.
        rb = rx_q.size();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rxd = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        check("midframe_busy", int'(rxd_busy), 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("midreset");
        rst_n = 1'b1;
        idle_bits(5);
        send_frame(8'h12, 1'b1);
        idle_bits(3);
        check("post_reset_ready", rx_q.size() - rb, 1);
        check("post_reset_data", int'(rxd_data), 8'h12);

        // Random frames against the byte-level model: a good stop bit always delivers;
        // a bad one delivers only without the framing check and is followed by idle.
        rb = rx_q.size(); eb = err_cnt; exp_err = 0;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       stop;
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, stop);
            idle_bits(stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)));
            if (stop || !FRAMING) exp_q.push_back(d);
            else exp_err++;
        end
        idle_bits(3);
        check("rand_count", rx_q.size() - rb, exp_q.size());
        check("rand_err", err_cnt - eb, exp_err);
        for (int i = 0; i < exp_q.size() && rb + i < rx_q.size(); i++)
            check($sformatf("rand_byte%0d", i), int'(rx_q[rb+i]), int'(exp_q[i]));

        check("strobe_shape", viol_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
